eth_arp_capture: RTL and testbench



---
 rtl/eth_arp_capture.sv | 195 +++++++++++++++++++
 tb/tb_eth_arp_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_arp_capture.sv
// eth_arp_capture: parses ARP frames from the GMII receive byte stream, checks
// the fixed header fields and latches the addresses into a holding set that the
// control CPU reads word by word and then releases with an acknowledge.
module eth_arp_capture #(
  parameter int ARP_LEN = 42,
  parameter int DROP_W  = 8
) (
  input  logic              i_rx_clk,
  input  logic              i_cmd_rst_n,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_dv,
  input  logic [31:0]       i_my_ip,
  input  logic              i_filter_en,
  input  logic              i_ack,
  input  logic [2:0]        i_rd_idx,
  output logic [31:0]       o_rd_data,
  output logic              o_pkt_valid,
  output logic [1:0]        o_pkt_op,
  output logic [DROP_W-1:0] o_drop_cnt
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRE      = 3'd1;
  localparam logic [2:0] ST_HDR      = 3'd2;
  localparam logic [2:0] ST_WAIT_END = 3'd3;
  localparam logic [2:0] ST_COMMIT   = 3'd4;

  localparam logic [5:0]        LAST_IDX = 6'(ARP_LEN - 1);
  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};
  localparam logic [DROP_W-1:0] DROP_ONE = {{(DROP_W-1){1'b0}}, 1'b1};

  // Returns 1 when a byte at a fixed-content header position does not match
  // the only acceptable Ethernet/IPv4 ARP value for that position.
  function automatic logic hdr_byte_bad(input logic [5:0] idx, input logic [7:0] b);
    logic bad;
    case (idx)
      6'd12:   bad = (b != 8'h08);
      6'd13:   bad = (b != 8'h06);
      6'd14:   bad = (b != 8'h00);
      6'd15:   bad = (b != 8'h01);
      6'd16:   bad = (b != 8'h08);
      6'd17:   bad = (b != 8'h00);
      6'd18:   bad = (b != 8'h06);
      6'd19:   bad = (b != 8'h04);
      6'd20:   bad = (b != 8'h00);
      6'd21:   bad = (b != 8'h01) && (b != 8'h02);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

  logic [2:0]  state_r;
  logic [2:0]  state_nxt_s;
  logic [5:0]  cnt_r;
  logic        bad_r;
  logic        complete_r;
  logic        filter_ok_s;
  logic        last_byte_s;

  logic [47:0] dst_w_r, sha_w_r, tha_w_r;
  logic [31:0] spa_w_r, tpa_w_r;
  logic [1:0]  op_w_r;

  logic [47:0] dst_h_r, sha_h_r, tha_h_r;
  logic [31:0] spa_h_r, tpa_h_r;

  assign filter_ok_s = !i_filter_en || (tpa_w_r == i_my_ip);
  assign last_byte_s = (cnt_r == LAST_IDX);

  // Next-state decode for the frame parser.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_rx_dv) begin
          if (i_rx_data == 8'h55) state_nxt_s = ST_PRE;
          else                    state_nxt_s = ST_WAIT_END;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PRE: begin
        if (i_rx_dv) begin
          if (i_rx_data == 8'h55)      state_nxt_s = ST_PRE;
          else if (i_rx_data == 8'hD5) state_nxt_s = ST_HDR;
          else                         state_nxt_s = ST_WAIT_END;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (i_rx_dv) begin
          if (last_byte_s) state_nxt_s = ST_WAIT_END;
          else             state_nxt_s = ST_HDR;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_END: begin
        if (i_rx_dv)                                  state_nxt_s = ST_WAIT_END;
        else if (complete_r && !bad_r && filter_ok_s) state_nxt_s = ST_COMMIT;
        else                                          state_nxt_s = ST_IDLE;
      end
      ST_COMMIT: state_nxt_s = ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // Parser state register.
  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) state_r <= ST_IDLE;
    else              state_r <= state_nxt_s;
  end

  // Byte counter, per-frame flags and working field capture (MSB first).
  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) begin
      cnt_r      <= 6'd0;
      bad_r      <= 1'b0;
      complete_r <= 1'b0;
      dst_w_r    <= 48'd0;
      sha_w_r    <= 48'd0;
      tha_w_r    <= 48'd0;
      spa_w_r    <= 32'd0;
      tpa_w_r    <= 32'd0;
      op_w_r     <= 2'd0;
    end else if (state_r == ST_PRE && i_rx_dv && i_rx_data == 8'hD5) begin
      cnt_r      <= 6'd0;
      bad_r      <= 1'b0;
      complete_r <= 1'b0;
    end else if (state_r == ST_HDR && i_rx_dv) begin
      cnt_r <= cnt_r + 6'd1;
      bad_r <= bad_r | hdr_byte_bad(cnt_r, i_rx_data);
      if (last_byte_s) complete_r <= 1'b1;
      if (cnt_r <= 6'd5)                       dst_w_r <= {dst_w_r[39:0], i_rx_data};
      else if (cnt_r == 6'd21)                 op_w_r  <= i_rx_data[1:0];
      else if (cnt_r >= 6'd22 && cnt_r <= 6'd27) sha_w_r <= {sha_w_r[39:0], i_rx_data};
      else if (cnt_r >= 6'd28 && cnt_r <= 6'd31) spa_w_r <= {spa_w_r[23:0], i_rx_data};
      else if (cnt_r >= 6'd32 && cnt_r <= 6'd37) tha_w_r <= {tha_w_r[39:0], i_rx_data};
      else if (cnt_r >= 6'd38)                 tpa_w_r <= {tpa_w_r[23:0], i_rx_data};
    end else if (state_r == ST_WAIT_END && !i_rx_dv) begin
      // Frame over: a later frame that skips HDR must not inherit this flag.
      complete_r <= 1'b0;
    end
  end

  // Holding set, pending flag and saturating drop counter.
  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) begin
      dst_h_r     <= 48'd0;
      sha_h_r     <= 48'd0;
      tha_h_r     <= 48'd0;
      spa_h_r     <= 32'd0;
      tpa_h_r     <= 32'd0;
      o_pkt_op    <= 2'd0;
      o_pkt_valid <= 1'b0;
      o_drop_cnt  <= {DROP_W{1'b0}};
    end else if (state_r == ST_COMMIT) begin
      // An ack in the commit cycle frees the set for the new frame.
      if (!o_pkt_valid || i_ack) begin
        dst_h_r     <= dst_w_r;
        sha_h_r     <= sha_w_r;
        tha_h_r     <= tha_w_r;
        spa_h_r     <= spa_w_r;
        tpa_h_r     <= tpa_w_r;
        o_pkt_op    <= op_w_r;
        o_pkt_valid <= 1'b1;
      end else if (o_drop_cnt != DROP_MAX) begin
        o_drop_cnt <= o_drop_cnt + DROP_ONE;
      end
    end else if (i_ack) begin
      o_pkt_valid <= 1'b0;
    end
  end

  // Registered word-indexed read of the holding set.
  always_ff @(posedge i_rx_clk or negedge i_cmd_rst_n) begin
    if (!i_cmd_rst_n) begin
      o_rd_data <= 32'd0;
    end else begin
      case (i_rd_idx)
        3'd0:    o_rd_data <= {16'h0000, dst_h_r[47:32]};
        3'd1:    o_rd_data <= dst_h_r[31:0];
        3'd2:    o_rd_data <= {16'h0000, sha_h_r[47:32]};
        3'd3:    o_rd_data <= sha_h_r[31:0];
        3'd4:    o_rd_data <= spa_h_r;
        3'd5:    o_rd_data <= {16'h0000, tha_h_r[47:32]};
        3'd6:    o_rd_data <= tha_h_r[31:0];
        3'd7:    o_rd_data <= tpa_h_r;
        default: o_rd_data <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_arp_capture.sv
// Scoreboard bench for eth_arp_capture: directed ARP frames, expected register
// words and status pushed into a queue, compared by an independent monitor.
module tb_eth_arp_capture;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_dv = 1'b0;
  logic [31:0] my_ip = 32'hC0A8010A;
  logic        filter_en = 1'b1;
  logic        ack = 1'b0;
  logic [2:0]  rd_idx = 3'd0;
  logic [31:0] rd_data;
  logic        pkt_valid;
  logic [1:0]  pkt_op;
  logic [7:0]  drop_cnt;

  eth_arp_capture #(.ARP_LEN(42), .DROP_W(8)) dut (
    .i_rx_clk(clk), .i_cmd_rst_n(rst_n), .i_rx_data(rx_data), .i_rx_dv(rx_dv),
    .i_my_ip(my_ip), .i_filter_en(filter_en), .i_ack(ack), .i_rd_idx(rd_idx),
    .o_rd_data(rd_data), .o_pkt_valid(pkt_valid), .o_pkt_op(pkt_op),
    .o_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_rd;
    logic [2:0]  idx;
    logic [31:0] exp;
  } item_t;

  item_t       sb_q[$];
  logic        chk_req = 1'b0;
  logic        req_d = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [7:0]  frm [0:41];

  // Monitor: one cycle after a request the DUT output is compared to the queue head.
  always @(posedge clk) req_d <= chk_req;

  always @(negedge clk) begin
    if (req_d) begin
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_underflow got output with no expectation");
      end else begin
        item_t it;
        logic [31:0] act;
        it = sb_q.pop_front();
        if (it.is_rd) act = rd_data;
        else          act = {21'd0, pkt_valid, pkt_op, drop_cnt};
        if (act !== it.exp) begin
          n_fail++;
          if (it.is_rd)
            $display("FAIL rd_idx%0d got %h expected %h", it.idx, act, it.exp);
          else
            $display("FAIL status got valid=%b op=%b drop=%0d expected valid=%b op=%b drop=%0d",
                     act[10], act[9:8], act[7:0], it.exp[10], it.exp[9:8], it.exp[7:0]);
        end
      end
    end
  end

  task automatic issue(input item_t it);
    sb_q.push_back(it);
    if (it.is_rd) rd_idx = it.idx;
    chk_req = 1'b1;
    @(negedge clk);
    chk_req = 1'b0;
  endtask

  task automatic exp_rd(input logic [2:0] idx, input logic [31:0] val);
    item_t it;
    it.is_rd = 1'b1; it.idx = idx; it.exp = val;
    issue(it);
  endtask

  task automatic exp_status(input logic v, input logic [1:0] op, input logic [7:0] drop);
    item_t it;
    it.is_rd = 1'b0; it.idx = 3'd0; it.exp = {21'd0, v, op, drop};
    issue(it);
  endtask

  task automatic build(input logic [47:0] dst, input logic [47:0] sha, input logic [31:0] spa,
                       input logic [47:0] tha, input logic [31:0] tpa,
                       input logic [15:0] oper, input logic [15:0] etype);
    for (int i = 0; i < 6; i++) begin
      frm[i]      = dst[47-8*i -: 8];
      frm[6+i]    = sha[47-8*i -: 8];
      frm[22+i]   = sha[47-8*i -: 8];
      frm[32+i]   = tha[47-8*i -: 8];
    end
    frm[12] = etype[15:8]; frm[13] = etype[7:0];
    frm[14] = 8'h00; frm[15] = 8'h01; frm[16] = 8'h08; frm[17] = 8'h00;
    frm[18] = 8'h06; frm[19] = 8'h04;
    frm[20] = oper[15:8]; frm[21] = oper[7:0];
    for (int i = 0; i < 4; i++) begin
      frm[28+i] = spa[31-8*i -: 8];
      frm[38+i] = tpa[31-8*i -: 8];
    end
  endtask

  task automatic drive_byte(input logic [7:0] b);
    rx_data = b; rx_dv = 1'b1;
    @(negedge clk);
  endtask

  // Preamble, SFD, header bytes [first..nbytes-1], padding/FCS, then idle gap.
  task automatic send(input int first, input int nbytes, input int pad,
                      input bit bad_pre, input bit ack_commit, input bit with_pre);
    if (with_pre) begin
      for (int i = 0; i < 6; i++) drive_byte(8'h55);
      drive_byte(bad_pre ? 8'h54 : 8'h55);
      drive_byte(8'hD5);
    end
    for (int i = first; i < nbytes; i++) drive_byte(frm[i]);
    if (nbytes == 42) begin
      for (int i = 0; i < pad + 4; i++) drive_byte(8'hA5);
    end
    rx_dv = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    if (ack_commit) ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    exp_status(1'b0, 2'b00, 8'd0);
    exp_rd(3'd7, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    exp_rd(3'd3, 32'd0);

    // ARP request, filter match
    build(48'hFFFFFFFFFFFF, 48'h001122334455, 32'hC0A80102, 48'h0, 32'hC0A8010A, 16'h0001, 16'h0806);
    send(0, 42, 18, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b01, 8'd0);
    exp_rd(3'd0, 32'h0000FFFF);
    exp_rd(3'd1, 32'hFFFFFFFF);
    exp_rd(3'd2, 32'h00000011);
    exp_rd(3'd3, 32'h22334455);
    exp_rd(3'd4, 32'hC0A80102);
    exp_rd(3'd7, 32'hC0A8010A);
    pulse_ack();
    exp_status(1'b0, 2'b01, 8'd0);
    exp_rd(3'd4, 32'hC0A80102);

    // Same frame, filter mismatch: silently discarded
    my_ip = 32'hC0A80109;
    send(0, 42, 18, 1'b0, 1'b0, 1'b1);
    exp_status(1'b0, 2'b01, 8'd0);
    my_ip = 32'hC0A8010A;

    // Runt after byte 30, then a valid reply
    send(0, 31, 0, 1'b0, 1'b0, 1'b1);
    exp_status(1'b0, 2'b01, 8'd0);
    build(48'h001122334455, 48'h66778899AABB, 32'hC0A80109, 48'h001122334455, 32'hC0A8010A, 16'h0002, 16'h0806);
    send(0, 42, 18, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b10, 8'd0);
    exp_rd(3'd2, 32'h00006677);
    exp_rd(3'd3, 32'h8899AABB);
    exp_rd(3'd5, 32'h00000011);
    exp_rd(3'd6, 32'h22334455);

    // Second valid frame without ack: dropped, first retained
    build(48'hFFFFFFFFFFFF, 48'h001122334455, 32'hC0A80102, 48'h0, 32'hC0A8010A, 16'h0001, 16'h0806);
    send(0, 42, 18, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b10, 8'd1);
    exp_rd(3'd3, 32'h8899AABB);
    exp_rd(3'd4, 32'hC0A80109);

    // Ack in the commit cycle of a new frame
    filter_en = 1'b0;
    build(48'hFFFFFFFFFFFF, 48'h0A0B0C0D0E0F, 32'h01020304, 48'h0, 32'h0A0B0C0D, 16'h0001, 16'h0806);
    send(0, 42, 18, 1'b0, 1'b1, 1'b1);
    exp_status(1'b1, 2'b01, 8'd1);
    exp_rd(3'd7, 32'h0A0B0C0D);
    exp_rd(3'd3, 32'h0C0D0E0F);
    pulse_ack();
    exp_status(1'b0, 2'b01, 8'd1);
    filter_en = 1'b1;

    // Wrong ethertype and broken preamble: no capture
    build(48'hFFFFFFFFFFFF, 48'h001122334455, 32'hC0A80102, 48'h0, 32'hC0A8010A, 16'h0001, 16'h0800);
    send(0, 42, 18, 1'b0, 1'b0, 1'b1);
    exp_status(1'b0, 2'b01, 8'd1);
    build(48'hFFFFFFFFFFFF, 48'h001122334455, 32'hC0A80102, 48'h0, 32'hC0A8010A, 16'h0001, 16'h0806);
    send(0, 42, 18, 1'b1, 1'b0, 1'b1);
    exp_status(1'b0, 2'b01, 8'd1);
    exp_rd(3'd7, 32'h0A0B0C0D);

    // Fill the set, then saturate the drop counter
    send(0, 42, 0, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b01, 8'd1);
    for (int n = 0; n < 253; n++) send(0, 42, 0, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b01, 8'd254);
    for (int n = 0; n < 3; n++) send(0, 42, 0, 1'b0, 1'b0, 1'b1);
    exp_status(1'b1, 2'b01, 8'd255);
    exp_rd(3'd4, 32'hC0A80102);

    // Reset mid-frame; the tail of the frame must not be captured
    pulse_ack();
    for (int i = 0; i < 6; i++) drive_byte(8'h55);
    drive_byte(8'h55);
    drive_byte(8'hD5);
    for (int i = 0; i < 10; i++) drive_byte(frm[i]);
    rst_n = 1'b0;
    exp_status(1'b0, 2'b00, 8'd0);
    exp_rd(3'd4, 32'd0);
    rst_n = 1'b1;
    send(10, 42, 18, 1'b0, 1'b0, 1'b0);
    exp_status(1'b0, 2'b00, 8'd0);
    exp_rd(3'd7, 32'd0);

    repeat (3) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
